plic_reg_arbiter: RTL
=====================

# plic_reg_arbiter

Round-robin arbiter sharing the single PLIC register-bus slave port (the reg_intf request/response pair of the PLIC top level) among N_MASTER requesters, e.g. per-hart debug and core ports. It guarantees at most one outstanding transaction at the slave. It never issues a slave request that is not owned by a granted master, because claim/complete register reads have side effects. A watchdog terminates any transaction the slave does not acknowledge within TIMEOUT cycles and returns an error.

## Interface
- N_MASTER, 2: number of requesters, 2..8.
- AW, 32: address width.
- DW, 32: data width; strobe width DW/8.
- TIMEOUT, 255: maximum cycles a slave transaction may stay unacknowledged. Counter width is $clog2(TIMEOUT+1).
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- m_valid_i  in  N_MASTER  per-master request valid; held until the matching m_ready_o.
- m_addr_i  in  N_MASTER×AW  per-master address.
- m_write_i  in  N_MASTER  1 = write, 0 = read.
- m_wdata_i  in  N_MASTER×DW  per-master write data.
- m_wstrb_i  in  N_MASTER×DW/8  per-master byte strobes.
- m_ready_o  out  N_MASTER  one-cycle completion pulse to the owning master.
- m_error_o  out  N_MASTER  error qualifier, valid with m_ready_o.
- m_rdata_o  out  DW  shared read data, valid only with m_ready_o.
- s_valid_o, s_addr_o, s_write_o, s_wdata_o, s_wstrb_o  out  1/AW/1/DW/DW/8  slave request.
- s_rdata_i  in  DW  slave read data.
- s_ready_i  in  1  slave completion.
- s_error_i  in  1  slave error.
- grant_o  out  N_MASTER  one-hot current owner; 0 when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

## Operation
- FSM has two states: IDLE and BUSY.
- IDLE
  - If any m_valid_i is set, select the first requesting index at or after rr_ptr, scanning upward modulo N_MASTER.
  - Register the owner index and the owner's addr/write/wdata/wstrb into slave holding registers.
  - Clear the watchdog counter and move to BUSY.
  - With no requests, stay in IDLE.
- BUSY
  - s_valid_o = 1; slave fields are driven from the holding registers, so they are stable regardless of master inputs.
  - grant_o is one-hot on the owner.
  - The counter increments each cycle s_ready_i = 0.
  - s_ready_i = 1, normal completion, same cycle and combinational:
    - m_ready_o[owner] = 1.
    - m_error_o[owner] = s_error_i.
    - m_rdata_o = s_rdata_i for reads, 0 for writes.
    - Next state IDLE; rr_ptr ← (owner+1) mod N_MASTER.
  - Counter == TIMEOUT with s_ready_i = 0:
    - m_ready_o[owner] = 1, m_error_o[owner] = 1, m_rdata_o = 0, timeout_o = 1.
    - s_valid_o is deasserted starting the next cycle.
    - Next state IDLE; rr_ptr advances as for normal completion.
  - s_ready_i in the same cycle the counter reaches TIMEOUT: normal completion wins and timeout_o stays 0.
- A master dropping m_valid_i while it owns the bus is a protocol violation. The latched transaction still completes at the slave and the m_ready_o pulse is still produced.
- Requests from non-owners are ignored in BUSY. They never see m_ready_o and are not lost; they remain pending.
- Outside a completion cycle, m_ready_o, m_error_o, m_rdata_o and timeout_o are all 0.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, rr_ptr 0, counter 0, holding registers 0.
  - Asynchronous assertion aborts any transaction immediately. s_valid_o drops without a slave handshake, and no m_ready_o is issued to the aborted master.
- Grant latency:
  - m_valid_i sampled in IDLE at edge k gives s_valid_o = 1 in cycle k+1.
  - Minimum total latency is 2 cycles: the grant cycle plus the BUSY cycle where s_ready_i = 1.
- Back-to-back behaviour:
  - At least one IDLE cycle always separates transactions.
  - Peak throughput is one transaction per 2 cycles.
  - A master that re-asserts m_valid_i in the cycle after its m_ready_o is arbitrated normally; rr_ptr already points past it.
- Fairness: with all masters continuously requesting, grants rotate 0,1,…,N_MASTER−1,0; worst-case wait is N_MASTER−1 transactions.
- Timeout timing: the watchdog fires in the (TIMEOUT+1)th BUSY cycle.

## Test plan
- Single read: master 0 requests addr 0x0C200004; slave returns ready after 3 cycles with rdata 0x00000005. Expect s_valid_o high for exactly 3 cycles, one m_ready_o[0] pulse with m_rdata_o = 5, m_error_o = 0, then grant_o = 0.
- Contention with N_MASTER = 3: all three request simultaneously from reset and each re-requests right after its completion. Expect grant order 0,1,2,0,1,2 and never two bits set in grant_o.
- Timeout with TIMEOUT = 4: slave never asserts ready. Expect s_valid_o high for 5 cycles, then m_ready_o[1], m_error_o[1] and timeout_o together, and s_valid_o low the next cycle.
- Race at the limit: s_ready_i arrives in the same cycle the counter hits TIMEOUT. Expect normal completion and timeout_o = 0.
- Stable slave fields: master 1 writes 0x7 with wstrb 0x1, then changes m_wdata_i mid-transaction. Expect s_wdata_o to stay 0x7 until completion, and m_error_o[1] to follow s_error_i = 1.
- Reset mid-operation: rst_i is asserted during BUSY. Expect all outputs 0 immediately and no m_ready_o; after release, the first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/plic_reg_arbiter.sv
// Round-robin arbiter sharing the PLIC register-bus slave port among N_MASTER requesters.
// Holds one outstanding slave transaction at a time, with a watchdog that terminates it with an error.
module plic_reg_arbiter #(
  parameter int unsigned N_MASTER = 2,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [N_MASTER-1:0]                m_valid_i,
  input  logic [N_MASTER-1:0][AW-1:0]        m_addr_i,
  input  logic [N_MASTER-1:0]                m_write_i,
  input  logic [N_MASTER-1:0][DW-1:0]        m_wdata_i,
  input  logic [N_MASTER-1:0][DW/8-1:0]      m_wstrb_i,
  output logic [N_MASTER-1:0]                m_ready_o,
  output logic [N_MASTER-1:0]                m_error_o,
  output logic [DW-1:0]                      m_rdata_o,
  output logic                               s_valid_o,
  output logic [AW-1:0]                      s_addr_o,
  output logic                               s_write_o,
  output logic [DW-1:0]                      s_wdata_o,
  output logic [DW/8-1:0]                    s_wstrb_o,
  input  logic [DW-1:0]                      s_rdata_i,
  input  logic                               s_ready_i,
  input  logic                               s_error_i,
  output logic [N_MASTER-1:0]                grant_o,
  output logic                               timeout_o
);

  localparam int unsigned IW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = DW / 8;
  localparam logic [IW:0]   N_W    = (IW+1)'(N_MASTER);
  localparam logic [IW-1:0] LAST   = IW'(N_MASTER - 1);
  localparam logic [CW-1:0] CNT_TO = CW'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q;
  logic [IW-1:0]        owner_q;
  logic [IW-1:0]        rr_ptr_q;
  logic [CW-1:0]        cnt_q;
  logic [AW-1:0]        addr_q;
  logic                 write_q;
  logic [DW-1:0]        wdata_q;
  logic [SW-1:0]        wstrb_q;

  logic [N_MASTER-1:0]  rot;
  logic [IW-1:0]        sel_off;
  logic [IW:0]          sel_sum;
  logic [IW-1:0]        sel_idx;
  logic                 sel_found;
  logic [IW-1:0]        next_ptr;
  logic [N_MASTER-1:0]  owner_oh;
  logic                 busy;
  logic                 done_ok;
  logic                 done_to;

  // Rotate requests so bit 0 is rr_ptr, pick the lowest set bit, then rotate back.
  always_comb begin
    rot       = N_MASTER'({m_valid_i, m_valid_i} >> rr_ptr_q);
    sel_found = |rot;
    sel_off   = '0;
    for (int i = N_MASTER - 1; i >= 0; i--) begin
      if (rot[i]) sel_off = IW'(i);
    end
    sel_sum = {1'b0, rr_ptr_q} + {1'b0, sel_off};
    if (sel_sum >= N_W) sel_sum = sel_sum - N_W;
    sel_idx = sel_sum[IW-1:0];
  end

  assign next_ptr = (owner_q == LAST) ? '0 : owner_q + IW'(1);
  assign owner_oh = N_MASTER'(1) << owner_q;
  assign busy     = (state_q == BUSY);
  assign done_ok  = busy && s_ready_i;
  assign done_to  = busy && !s_ready_i && (cnt_q == CNT_TO);

  // Arbitration FSM; slave fields are latched at grant and held for the whole transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            owner_q <= sel_idx;
            addr_q  <= m_addr_i[sel_idx];
            write_q <= m_write_i[sel_idx];
            wdata_q <= m_wdata_i[sel_idx];
            wstrb_q <= m_wstrb_i[sel_idx];
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (done_ok || done_to) begin
            state_q  <= IDLE;
            rr_ptr_q <= next_ptr;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_valid_o = busy;
  assign s_addr_o  = addr_q;
  assign s_write_o = write_q;
  assign s_wdata_o = wdata_q;
  assign s_wstrb_o = wstrb_q;
  assign grant_o   = busy ? owner_oh : '0;

  // Completion responses are combinational so the master sees them in the slave's ready cycle.
  assign m_ready_o = (done_ok || done_to) ? owner_oh : '0;
  assign m_error_o = (done_to || (done_ok && s_error_i)) ? owner_oh : '0;
  assign m_rdata_o = (done_ok && !write_q) ? s_rdata_i : '0;
  assign timeout_o = done_to;

endmodule
